// File: rtl/idi_pkg.sv
// idi_pkg: shared FSM states, response codes and IDI widths for the AXI-Lite to IDI bridge.
package idi_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, RWAIT, BRESP, RRESP} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int IDI_ADDR_W = 64;
  localparam int IDI_DATA_W = 32;
endpackage

// File: rtl/axi_to_idi_if.sv
// axi_to_idi_if: AXI4-Lite slave channels plus the IDI request/completion signals.
interface axi_to_idi_if;
  logic [31:0] S_AWADDR;
  logic S_AWVALID, S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0] S_WSTRB;
  logic S_WVALID, S_WREADY;
  logic [1:0] S_BRESP;
  logic S_BVALID, S_BREADY;
  logic [31:0] S_ARADDR;
  logic S_ARVALID, S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0] S_RRESP;
  logic S_RVALID, S_RREADY;
  logic idi_valid, idi_ready, idi_is_write, idi_rvalid;
  logic [idi_pkg::IDI_ADDR_W-1:0] idi_addr;
  logic [idi_pkg::IDI_DATA_W-1:0] idi_wdata, idi_rdata;
  modport slave (
    input S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY, S_ARADDR, S_ARVALID, S_RREADY,
    input idi_ready, idi_rdata, idi_rvalid,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY, S_RDATA, S_RRESP, S_RVALID,
    output idi_valid, idi_is_write, idi_addr, idi_wdata
  );
  modport master (
    output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY, S_ARADDR, S_ARVALID, S_RREADY,
    output idi_ready, idi_rdata, idi_rvalid,
    input S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY, S_RDATA, S_RRESP, S_RVALID,
    input idi_valid, idi_is_write, idi_addr, idi_wdata
  );
endinterface

// File: rtl/axi_to_idi.sv
// axi_to_idi: single-slot AXI4-Lite slave bridging one request at a time onto an in-order IDI port.
module axi_to_idi import idi_pkg::*; #(
  parameter logic [31:0] ADDR_HI = 32'h0,
  parameter int TIMEOUT = 256
) (
  input logic clk,
  input logic rst,
  axi_to_idi_if.slave bus,
  output logic err_timeout
);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  state_t state, state_n;
  logic live, aw_full, w_full, ar_full, pri_w, pri_w_n, cur_w, cur_w_n, err_n, free_w, free_r;
  logic aw_hs, w_hs, ar_hs, wr_ok, rd_ok, wr_bad, rd_bad, issue;
  logic [31:0] aw_addr, w_data, ar_addr, aw_a, ar_a, rdata, rdata_n, cnt, cnt_n;
  logic [3:0] w_strb, w_s;
  logic [1:0] resp, resp_n;
  // live keeps READY low until the first cycle after reset is released
  assign bus.S_AWREADY = live && !aw_full;
  assign bus.S_WREADY = live && !w_full;
  assign bus.S_ARREADY = live && !ar_full;
  assign aw_hs = bus.S_AWVALID && bus.S_AWREADY;
  assign w_hs = bus.S_WVALID && bus.S_WREADY;
  assign ar_hs = bus.S_ARVALID && bus.S_ARREADY;
  // a slot being filled this cycle already counts, giving the one-cycle path to ISSUE
  assign aw_a = aw_full ? aw_addr : bus.S_AWADDR;
  assign w_s = w_full ? w_strb : bus.S_WSTRB;
  assign ar_a = ar_full ? ar_addr : bus.S_ARADDR;
  assign wr_ok = (aw_full || aw_hs) && (w_full || w_hs);
  assign rd_ok = ar_full || ar_hs;
  assign wr_bad = w_s != 4'hF || aw_a[1:0] != 2'b00;
  assign rd_bad = ar_a[1:0] != 2'b00;
  assign issue = state == ISSUE;
  assign bus.idi_valid = issue;
  assign bus.idi_is_write = issue && cur_w;
  assign bus.idi_addr = issue ? {ADDR_HI, cur_w ? aw_addr : ar_addr} : '0;
  assign bus.idi_wdata = issue && cur_w ? w_data : '0;
  assign bus.S_BVALID = state == BRESP;
  assign bus.S_BRESP = bus.S_BVALID ? resp : RESP_OKAY;
  assign bus.S_RVALID = state == RRESP;
  assign bus.S_RRESP = bus.S_RVALID ? resp : RESP_OKAY;
  assign bus.S_RDATA = bus.S_RVALID ? rdata : '0;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    pri_w_n = pri_w;
    cur_w_n = cur_w;
    resp_n = resp;
    rdata_n = rdata;
    cnt_n = cnt;
    err_n = err_timeout;
    free_w = 1'b0;
    free_r = 1'b0;
    case (state)
      IDLE: begin
        if (wr_ok && (pri_w || !rd_ok)) begin
          cur_w_n = 1'b1;
          pri_w_n = 1'b0;
          state_n = wr_bad ? BRESP : ISSUE;
          resp_n = RESP_SLVERR;
          free_w = wr_bad;
        end else if (rd_ok) begin
          cur_w_n = 1'b0;
          pri_w_n = 1'b1;
          state_n = rd_bad ? RRESP : ISSUE;
          resp_n = RESP_SLVERR;
          rdata_n = '0;
          free_r = rd_bad;
        end
      end
      ISSUE: if (bus.idi_ready) begin
        resp_n = RESP_OKAY;
        cnt_n = '0;
        free_w = cur_w;
        free_r = !cur_w;
        rdata_n = bus.idi_rdata;
        state_n = cur_w ? BRESP : bus.idi_rvalid ? RRESP : RWAIT;
      end
      RWAIT: begin
        cnt_n = cnt + 32'd1;
        if (bus.idi_rvalid) begin
          rdata_n = bus.idi_rdata;
          state_n = RRESP;
        end else if (cnt == TO_LAST) begin
          resp_n = RESP_SLVERR;
          rdata_n = '0;
          err_n = 1'b1;
          state_n = RRESP;
        end
      end
      BRESP: state_n = bus.S_BREADY ? IDLE : BRESP;
      RRESP: state_n = bus.S_RREADY ? IDLE : RRESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      live <= 1'b0;
      {aw_full, w_full, ar_full} <= '0;
      {aw_addr, w_data, w_strb, ar_addr} <= '0;
      pri_w <= 1'b1;
      cur_w <= 1'b0;
      resp <= RESP_OKAY;
      rdata <= '0;
      cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      live <= 1'b1;
      aw_full <= (aw_full || aw_hs) && !free_w;
      w_full <= (w_full || w_hs) && !free_w;
      ar_full <= (ar_full || ar_hs) && !free_r;
      aw_addr <= aw_hs ? bus.S_AWADDR : aw_addr;
      w_data <= w_hs ? bus.S_WDATA : w_data;
      w_strb <= w_hs ? bus.S_WSTRB : w_strb;
      ar_addr <= ar_hs ? bus.S_ARADDR : ar_addr;
      pri_w <= pri_w_n;
      cur_w <= cur_w_n;
      resp <= resp_n;
      rdata <= rdata_n;
      cnt <= cnt_n;
      err_timeout <= err_n;
    end
  end
endmodule

// File: tb/tb_axi_to_idi.sv
// tb_axi_to_idi: directed and randomized checks of the bridge against a transaction-level model and memory sink.
module tb_axi_to_idi;
  import idi_pkg::*;
  localparam int TO = 16;
  typedef struct packed {logic w; logic [63:0] a; logic [31:0] d;} req_t;
  logic clk = 1'b0, rst = 1'b1, err_timeout;
  int checks = 0, errors = 0;
  int rdy_cfg = 0, rv_cfg = 1, rdy_left = 0, pdly = 0, vcnt = 0;
  bit rdy_rand = 0, rv_rand = 0, rv_en = 1, pend = 0;
  logic [31:0] paddr;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] model [logic [31:0]];
  req_t obs_q[$], exp_q[$];
  always #5 clk = ~clk;
  axi_to_idi_if bus();
  axi_to_idi #(.ADDR_HI(32'h0), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus), .err_timeout(err_timeout));

  function automatic req_t mk(input logic w, input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.w = w;
    r.a = {32'h0, a};
    r.d = d;
    return r;
  endfunction

  function automatic logic [31:0] mval(input logic [31:0] a);
    return model.exists(a) ? model[a] : 32'h0;
  endfunction

  // IDI memory sink: decides ready/rvalid at negedges for the coming posedge
  always @(negedge clk) begin
    req_t r;
    bus.idi_rvalid = 1'b0;
    if (bus.idi_valid) vcnt++;
    if (pend) begin
      pdly--;
      if (pdly <= 0) begin
        bus.idi_rvalid = 1'b1;
        bus.idi_rdata = mem.exists(paddr) ? mem[paddr] : 32'h0;
        pend = 0;
      end
    end
    if (bus.idi_valid) begin
      if (rdy_left == 0) begin
        bus.idi_ready = 1'b1;
        r.w = bus.idi_is_write;
        r.a = bus.idi_addr;
        r.d = bus.idi_wdata;
        obs_q.push_back(r);
        if (bus.idi_is_write) mem[bus.idi_addr[31:0]] = bus.idi_wdata;
        else if (rv_en) begin
          paddr = bus.idi_addr[31:0];
          pdly = rv_rand ? int'($urandom_range(0, 5)) : rv_cfg;
          if (pdly == 0) begin
            bus.idi_rvalid = 1'b1;
            bus.idi_rdata = mem.exists(paddr) ? mem[paddr] : 32'h0;
          end else pend = 1;
        end
      end else begin
        bus.idi_ready = 1'b0;
        rdy_left--;
      end
    end else begin
      bus.idi_ready = 1'b0;
      rdy_left = rdy_rand ? int'($urandom_range(0, 3)) : rdy_cfg;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ctl"}, {bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID, bus.S_BRESP, bus.S_ARREADY, bus.S_RVALID,
        bus.S_RRESP, bus.S_RDATA, bus.idi_valid, bus.idi_is_write, bus.idi_wdata, err_timeout}, 128'h0);
    chk({tag, "_addr"}, bus.idi_addr, 128'h0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      all_zero("reset");
    end
    rst = 1'b0;
    chk("ready_low_at_release", {bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY}, 128'h0);
    @(negedge clk);
    chk("ready_rise", {bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY}, 128'h7);
  endtask

  task automatic axi_xfer(input bit dw, input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                          input int lead, input bit dr, input logic [31:0] ra);
    bit awd, wdn, ard;
    int n;
    awd = !dw;
    wdn = !dw;
    ard = !dr;
    n = 0;
    while (!(awd && wdn && ard) && n < 100) begin
      bus.S_AWADDR = wa;
      bus.S_WDATA = wd;
      bus.S_WSTRB = ws;
      bus.S_ARADDR = ra;
      bus.S_AWVALID = !awd && n >= lead;
      bus.S_WVALID = !wdn;
      bus.S_ARVALID = !ard;
      if (bus.S_AWVALID && bus.S_AWREADY) awd = 1;
      if (bus.S_WVALID && bus.S_WREADY) wdn = 1;
      if (bus.S_ARVALID && bus.S_ARREADY) ard = 1;
      @(negedge clk);
      n++;
    end
    bus.S_AWVALID = 1'b0;
    bus.S_WVALID = 1'b0;
    bus.S_ARVALID = 1'b0;
    chk("accept", {awd, wdn, ard}, 128'h7);
  endtask

  task automatic take_b(input string tag, input logic [1:0] exp, input int hold);
    int n;
    n = 0;
    while (!bus.S_BVALID && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_bvalid"}, bus.S_BVALID, 128'h1);
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_bhold"}, {bus.S_BVALID, bus.S_BRESP}, {1'b1, exp});
    end
    chk({tag, "_bresp"}, bus.S_BRESP, exp);
    bus.S_BREADY = 1'b1;
    @(negedge clk);
    bus.S_BREADY = 1'b0;
    chk({tag, "_bdone"}, bus.S_BVALID, 128'h0);
  endtask

  task automatic take_r(input string tag, input logic [1:0] er, input logic [31:0] ed, input int hold, output int n);
    n = 0;
    while (!bus.S_RVALID && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rvalid"}, bus.S_RVALID, 128'h1);
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_rhold"}, {bus.S_RVALID, bus.S_RRESP, bus.S_RDATA}, {1'b1, er, ed});
    end
    chk({tag, "_rpayload"}, {bus.S_RRESP, bus.S_RDATA}, {er, ed});
    bus.S_RREADY = 1'b1;
    @(negedge clk);
    bus.S_RREADY = 1'b0;
    chk({tag, "_rdone"}, bus.S_RVALID, 128'h0);
  endtask

  task automatic cmp_reqs(input string tag);
    req_t o, e;
    chk({tag, "_nreq"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_req"}, {o.w, o.a, o.w ? o.d : 32'h0}, {e.w, e.a, e.w ? e.d : 32'h0});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, v0;
    {bus.S_AWADDR, bus.S_AWVALID, bus.S_WDATA, bus.S_WSTRB, bus.S_WVALID, bus.S_BREADY} = '0;
    {bus.S_ARADDR, bus.S_ARVALID, bus.S_RREADY} = '0;
    @(negedge clk);
    do_reset(3);
    // minimum-latency write
    bus.S_AWADDR = 32'h100;
    bus.S_WDATA = 32'hDEADBEEF;
    bus.S_WSTRB = 4'hF;
    bus.S_AWVALID = 1'b1;
    bus.S_WVALID = 1'b1;
    chk("lat_ready", {bus.S_AWREADY, bus.S_WREADY}, 128'h3);
    exp_q.push_back(mk(1'b1, 32'h100, 32'hDEADBEEF));
    model[32'h100] = 32'hDEADBEEF;
    @(negedge clk);
    bus.S_AWVALID = 1'b0;
    bus.S_WVALID = 1'b0;
    chk("lat_idi", {bus.idi_valid, bus.idi_is_write, bus.idi_wdata}, {1'b1, 1'b1, 32'hDEADBEEF});
    chk("lat_addr", bus.idi_addr, 128'h100);
    @(negedge clk);
    chk("lat_b", {bus.S_BVALID, bus.S_BRESP}, {1'b1, RESP_OKAY});
    bus.S_BREADY = 1'b1;
    @(negedge clk);
    bus.S_BREADY = 1'b0;
    // W leads AW, then delayed read completion
    axi_xfer(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 3, 1'b0, 32'h0);
    exp_q.push_back(mk(1'b1, 32'h100, 32'hDEADBEEF));
    take_b("wlead", RESP_OKAY, 0);
    rv_cfg = 4;
    exp_q.push_back(mk(1'b0, 32'h100, 32'h0));
    axi_xfer(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b1, 32'h100);
    take_r("rd100", RESP_OKAY, mval(32'h100), 0, n);
    cmp_reqs("basic");
    // simultaneous write+read twice: grants alternate starting with write
    do_reset(1);
    bus.S_BREADY = 1'b1;
    bus.S_RREADY = 1'b1;
    rv_cfg = 1;
    axi_xfer(1'b1, 32'h10, 32'h11110010, 4'hF, 0, 1'b1, 32'h20);
    axi_xfer(1'b1, 32'h10, 32'h22220010, 4'hF, 0, 1'b1, 32'h20);
    repeat (30) @(negedge clk);
    bus.S_BREADY = 1'b0;
    bus.S_RREADY = 1'b0;
    exp_q.push_back(mk(1'b1, 32'h10, 32'h11110010));
    exp_q.push_back(mk(1'b0, 32'h20, 32'h0));
    exp_q.push_back(mk(1'b1, 32'h10, 32'h22220010));
    exp_q.push_back(mk(1'b0, 32'h20, 32'h0));
    model[32'h10] = 32'h22220010;
    cmp_reqs("order");
    // illegal strobes / alignment never reach IDI
    v0 = vcnt;
    axi_xfer(1'b1, 32'h40, 32'h12345678, 4'h3, 0, 1'b0, 32'h0);
    take_b("strb", RESP_SLVERR, 1);
    axi_xfer(1'b1, 32'h41, 32'h12345678, 4'hF, 0, 1'b0, 32'h0);
    take_b("awmis", RESP_SLVERR, 0);
    axi_xfer(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b1, 32'h102);
    take_r("armis", RESP_SLVERR, 32'h0, 1, n);
    chk("illegal_no_idi", vcnt - v0, 128'h0);
    cmp_reqs("illegal");
    // read timeout sets the sticky flag
    rv_en = 0;
    chk("err_clear", err_timeout, 128'h0);
    exp_q.push_back(mk(1'b0, 32'h200, 32'h0));
    axi_xfer(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b1, 32'h200);
    take_r("tmo", RESP_SLVERR, 32'h0, 0, n);
    chk("tmo_latency", n >= TO + 1 && n <= TO + 2, 128'h1);
    chk("err_set", err_timeout, 128'h1);
    rv_en = 1;
    exp_q.push_back(mk(1'b1, 32'h204, 32'h0BADF00D));
    model[32'h204] = 32'h0BADF00D;
    axi_xfer(1'b1, 32'h204, 32'h0BADF00D, 4'hF, 0, 1'b0, 32'h0);
    take_b("after_tmo", RESP_OKAY, 0);
    chk("err_sticky", err_timeout, 128'h1);
    cmp_reqs("tmo");
    do_reset(2);
    // backpressure on both sides, then reset while waiting for completion
    rdy_cfg = 3;
    exp_q.push_back(mk(1'b1, 32'h300, 32'hCAFE0300));
    model[32'h300] = 32'hCAFE0300;
    axi_xfer(1'b1, 32'h300, 32'hCAFE0300, 4'hF, 0, 1'b0, 32'h0);
    repeat (3) begin
      chk("stall_idi", {bus.idi_valid, bus.idi_is_write, bus.idi_wdata}, {1'b1, 1'b1, 32'hCAFE0300});
      chk("stall_addr", bus.idi_addr, 128'h300);
      @(negedge clk);
    end
    rdy_cfg = 0;
    take_b("bhold", RESP_OKAY, 5);
    rv_cfg = 8;
    exp_q.push_back(mk(1'b0, 32'h300, 32'h0));
    axi_xfer(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b1, 32'h300);
    @(negedge clk);
    chk("rwait_busy", bus.S_RVALID, 128'h0);
    do_reset(2);
    v0 = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.S_RVALID || bus.S_BVALID || bus.idi_valid) v0++;
    end
    chk("stale_ignored", v0, 128'h0);
    rv_cfg = 2;
    exp_q.push_back(mk(1'b1, 32'h304, 32'h5A5A0304));
    model[32'h304] = 32'h5A5A0304;
    axi_xfer(1'b1, 32'h304, 32'h5A5A0304, 4'hF, 0, 1'b0, 32'h0);
    take_b("post_rst_w", RESP_OKAY, 0);
    exp_q.push_back(mk(1'b0, 32'h304, 32'h0));
    axi_xfer(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b1, 32'h304);
    take_r("post_rst_r", RESP_OKAY, mval(32'h304), 0, n);
    cmp_reqs("rst");
    // randomized traffic against the model
    rdy_rand = 1;
    rv_rand = 1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, d;
      logic [3:0] s;
      bit ok;
      a = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        s = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
        ok = s == 4'hF && a[1:0] == 2'b00;
        if (ok) begin
          exp_q.push_back(mk(1'b1, a, d));
          model[a] = d;
        end
        axi_xfer(1'b1, a, d, s, int'($urandom_range(0, 3)), 1'b0, 32'h0);
        take_b("rnd_w", ok ? RESP_OKAY : RESP_SLVERR, int'($urandom_range(0, 2)));
      end else begin
        ok = a[1:0] == 2'b00;
        if (ok) exp_q.push_back(mk(1'b0, a, 32'h0));
        axi_xfer(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b1, a);
        take_r("rnd_r", ok ? RESP_OKAY : RESP_SLVERR, ok ? mval(a) : 32'h0, int'($urandom_range(0, 2)), n);
      end
    end
    cmp_reqs("rnd");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
